mdu_iter: RTL and testbench

Parametrised multiply/divide unit for the 5-stage MIPS pipeline, sitting in the Execute stage beside the ALU. Accepts one HI/LO operation per start pulse and holds `busy` for a configurable number of cycles; the hazard unit stalls HI/LO consumers on `start | busy`. Generalises the fixed 32-bit, fixed-latency unit:
- operand width and per-class latency are parameters;
- adds accumulate modes (madd/msub), divide-by-zero protection, and a cancel input for flushing an in-flight operation.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_div_core.sv | 55 +++++
 rtl/mdu_iter.sv | 166 ++++++++++++++++
 tb/tb_mdu_iter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mdu_pkg
// Description : Op encodings, FSM state type and latency helpers for mdu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_timed(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_timed = 1'b1;
            default:                              is_timed = 1'b0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input int mult_cycles,
                                   input int div_cycles);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU: latency = mult_cycles;
            OP_DIV, OP_DIVU:   latency = div_cycles;
            default:           latency = 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_core
// Description : Combinational signed/unsigned quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_safe;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic             w_ovf;

    // Magnitudes work for the most-negative value too: -MIN wraps back to MIN,
    // which is the correct unsigned magnitude.
    assign w_a_neg  = is_signed & a[WIDTH-1];
    assign w_b_neg  = is_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a + C_ONE) : a;
    assign w_b_mag  = w_b_neg ? (~b + C_ONE) : b;
    assign div_zero = (b == '0);
    assign w_b_safe = div_zero ? C_ONE : w_b_mag;
    assign w_uq     = w_a_mag / w_b_safe;
    assign w_ur     = w_a_mag % w_b_safe;
    assign w_ovf    = is_signed & (a == C_MIN) & (b == '1);

    always_comb begin
        quo = (w_a_neg ^ w_b_neg) ? (~w_uq + C_ONE) : w_uq;
        rem = w_a_neg ? (~w_ur + C_ONE) : w_ur;
        if (div_zero) begin
            quo = '0;
            rem = '0;
        end else if (w_ovf) begin
            quo = C_MIN;
            rem = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Multi-cycle HI/LO multiply/divide/accumulate unit for Execute.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    generate
        if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
            $error("mdu_iter: MULT_CYCLES and DIV_CYCLES must be >= 1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;

    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc_add;
    logic [2*WIDTH-1:0] w_acc_sub;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;

    // Operands are extended to 2*WIDTH so one unsigned multiplier yields the
    // exact signed or unsigned product modulo 2^(2*WIDTH).
    assign w_mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    assign w_a_ext      = {{WIDTH{w_mul_signed & a[WIDTH-1]}}, a};
    assign w_b_ext      = {{WIDTH{w_mul_signed & b[WIDTH-1]}}, b};
    assign w_prod       = w_a_ext * w_b_ext;
    assign w_acc_add    = {hi_q, lo_q} + w_prod;
    assign w_acc_sub    = {hi_q, lo_q} - w_prod;

    mdu_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .a        (a),
        .b        (b),
        .is_signed(op == OP_DIV),
        .quo      (w_quo),
        .rem      (w_rem),
        .div_zero (w_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = w_prod;
                            pend_dz_d              = 1'b0;
                        end
                        OP_MADD, OP_MADDU: begin
                            {pend_hi_d, pend_lo_d} = w_acc_add;
                            pend_dz_d              = 1'b0;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            {pend_hi_d, pend_lo_d} = w_acc_sub;
                            pend_dz_d              = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = w_rem;
                            pend_lo_d = w_quo;
                            pend_dz_d = w_div_zero;
                        end
                        default: ;
                    endcase
                    if (is_timed(op)) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(latency(op, MULT_CYCLES, DIV_CYCLES));
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        state_d = ST_IDLE;
                        if (!pend_dz_q) begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for mdu_iter with a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = OP_NOP;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    mdu_iter #(
        .WIDTH      (32),
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Model: an accepted op is resolved immediately with 64-bit arithmetic and
    // tagged with the edge number at which it lands in HI/LO.
    longint      e      = 0;
    longint      m_done = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_pdz = 1'b0;

    task automatic model_accept(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint unsigned acc, prod, res;
        int              sx, sy;
        int unsigned     ux, uy;
        sx   = x;  sy = y;  ux = x;  uy = y;
        acc  = {m_hi, m_lo};
        prod = 64'(longint'(sx) * longint'(sy));
        if (o == OP_MULTU || o == OP_MADDU || o == OP_MSUBU)
            prod = {32'b0, x} * {32'b0, y};
        m_pdz = 1'b0;
        res   = prod;
        case (o)
            OP_MTHI: m_hi = x;
            OP_MTLO: m_lo = x;
            OP_MADD, OP_MADDU: res = acc + prod;
            OP_MSUB, OP_MSUBU: res = acc - prod;
            OP_DIV: begin
                if (y == 0) m_pdz = 1'b1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) res = {32'h0, x};
                else res = {32'(sx % sy), 32'(sx / sy)};
            end
            OP_DIVU: begin
                if (y == 0) m_pdz = 1'b1;
                else res = {ux % uy, ux / uy};
            end
            default: ;
        endcase
        m_phi = res[63:32];
        m_plo = res[31:0];
        if (is_timed(o))
            m_done = e + ((o == OP_DIV || o == OP_DIVU) ? DC : MC);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pdz = 1'b0; m_done = 0;
        end else begin
            e = e + 1;
            if (e - 1 < m_done) begin
                if (start) begin
                    tests++; fails++;
                    $display("FAIL start_in_run: start=%b while busy, required 0", start);
                end
                if (cancel) m_done = e;
                else if (e == m_done && !m_pdz) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end else if (start && !cancel) begin
                model_accept(op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            tests += 3;
            if (busy !== (e < m_done)) begin
                fails++;
                $display("FAIL cyc_busy @%0t: got %b required %b", $time, busy, (e < m_done));
            end
            if (hi !== m_hi) begin
                fails++;
                $display("FAIL cyc_hi @%0t: got %h required %h", $time, hi, m_hi);
            end
            if (lo !== m_lo) begin
                fails++;
                $display("FAIL cyc_lo @%0t: got %h required %h", $time, lo, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Issue one op from the current negedge; returns the number of busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int nb);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 64) begin
            nb++;
            @(negedge clk);
        end
        if (nb >= 64) begin
            tests++; fails++;
            $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", busy, nb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1);
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        #1 reset = 1'b1;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd3, nb);
        chk("mult_busy", nb, MC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFD);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd3, nb);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFD);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
        chk("div_busy", nb, DC);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nb);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'h0000_0001);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);
        run_op(OP_DIVU, 32'd5, 32'd0, nb);
        chk("divz_busy", nb, DC);
        chk("divz_hi", hi, 32'h0);
        chk("divz_lo", lo, 32'h8000_0000);

        run_op(OP_MTHI, 32'h1234_5678, 32'd0, nb);
        chk("mthi_busy", nb, 0);
        chk("mthi_hi", hi, 32'h1234_5678);
        run_op(OP_MADDU, 32'd2, 32'd3, nb);
        chk("maddu_hi", hi, 32'h1234_5678);
        chk("maddu_lo", lo, 32'h8000_0006);
        run_op(OP_MTLO, 32'hFFFF_FFFE, 32'd0, nb);
        run_op(OP_MADDU, 32'd2, 32'd3, nb);
        chk("maddu_cy_hi", hi, 32'h1234_5679);
        chk("maddu_cy_lo", lo, 32'h0000_0004);
        run_op(OP_MTHI, 32'd0, 32'd0, nb);
        run_op(OP_MTLO, 32'd0, 32'd0, nb);
        run_op(OP_MSUB, 32'd1, 32'd1, nb);
        chk("msub_hi", hi, 32'hFFFF_FFFF);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
        run_op(OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        chk("madd_hi", hi, 32'h0);
        chk("madd_lo", lo, 32'h0);
        run_op(OP_MSUBU, 32'd2, 32'd3, nb);
        chk("msubu_hi", hi, 32'hFFFF_FFFF);
        chk("msubu_lo", lo, 32'hFFFF_FFFA);
        run_op(4'hF, 32'd9, 32'd9, nb);
        chk("nop_busy", nb, 0);
        chk("nop_lo", lo, 32'hFFFF_FFFA);

        run_op(OP_MTHI, 32'hAAAA_AAAA, 32'd0, nb);
        run_op(OP_MTLO, 32'h5555_5555, 32'd0, nb);
        op = OP_MULT; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cancel_pre_busy", {31'b0, busy}, 32'h1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'b0, busy}, 32'h0);
        chk("cancel_hi", hi, 32'hAAAA_AAAA);
        chk("cancel_lo", lo, 32'h5555_5555);
        run_op(OP_DIV, 32'd100, 32'd7, nb);
        chk("post_cancel_busy", nb, DC);
        chk("post_cancel_lo", lo, 32'h0000_000E);
        chk("post_cancel_hi", hi, 32'h0000_0002);
        cancel = 1'b1;
        run_op(OP_MULT, 32'd7, 32'd9, nb);
        cancel = 1'b0;
        chk("cancel_start_busy", nb, 0);
        chk("cancel_start_lo", lo, 32'h0000_000E);

        op = OP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        run_op(OP_MULTU, 32'd2, 32'd2, nb);
        chk("post_rst_busy", nb, MC);
        chk("post_rst_lo", lo, 32'h4);
        chk("post_rst_hi", hi, 32'h0);

        run_op(OP_MULT, 32'd3, 32'd4, nb);
        chk("b2b_first_busy", nb, MC);
        chk("b2b_first_lo", lo, 32'h0000_000C);
        run_op(OP_MULT, 32'd5, 32'd6, nb);
        chk("b2b_second_busy", nb, MC);
        chk("b2b_second_lo", lo, 32'h0000_001E);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
